// File: rtl/mio_ps2_pkg.sv
// Shared definitions for the MIO PS/2 receiver: FSM states, status bit positions, register selects.
package mio_ps2_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } ps2_state_e;

    localparam int ST_AVAIL = 0;
    localparam int ST_RSVD  = 1;
    localparam int ST_LPAR  = 2;
    localparam int ST_CLK   = 3;
    localparam int ST_FULL  = 4;
    localparam int ST_PERR  = 5;
    localparam int ST_FERR  = 6;
    localparam int ST_OVR   = 7;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

endpackage

// File: rtl/ps2_sync_fifo.sv
// Small synchronous FIFO for received PS/2 bytes; power-of-two depth, async active-high reset.
module ps2_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    always_comb begin
        do_pop   = pop & (count_q != '0);
        do_push  = push & ((count_q != CW'(DEPTH)) | do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with byte FIFO, sticky error flags and a Z180 bus status port.
// Optional mid-frame timeout abort is enabled by defining PS2_RX_TIMEOUT_EN.
import mio_ps2_pkg::*;

module ps2_rx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int FILTER_LEN = 4
`ifdef PS2_RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16384
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       addr,
    input  logic       rd,
    output logic [7:0] data_out,
    output logic       kb_int,
    input  logic       in_clk,
    input  logic       in_data
);

    localparam int FW = $clog2(FILTER_LEN);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          clk_filt_q, clk_filt_d;
    ps2_state_e    state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          par_q, par_d;
    logic          ovr_q, ovr_d, ferr_q, ferr_d, perr_q, perr_d;
    logic          kb_int_q, kb_int_d;
    logic          fall, push, pop, status_rd;
    logic          ovr_set, ferr_set, perr_set;
    logic          full, empty;
    logic [7:0]    head;
    logic [7:0]    status;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

    ps2_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (shift_q),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign pop       = rd & (addr == REG_DATA) & ~empty;
    assign status_rd = rd & (addr == REG_STATUS);

    // The filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != clk_filt_q) begin
            if (filt_cnt_q == FILT_MAX) begin
                clk_filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    assign fall = clk_filt_q & ~clk_filt_d;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        push      = 1'b0;
        ovr_set   = 1'b0;
        ferr_set  = 1'b0;
        perr_set  = 1'b0;
        if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!dat_s2_q) begin
                        shift_d   = '0;
                        bit_cnt_d = '0;
                        state_d   = S_DATA;
                    end
                end
                S_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!dat_s2_q) begin
                        ferr_set = 1'b1;
                    end else if (~^{shift_q, par_q}) begin
                        perr_set = 1'b1;
                    end else if (full && !pop) begin
                        ovr_set = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
`ifdef PS2_RX_TIMEOUT_EN
        to_cnt_d = (state_q == S_IDLE || fall) ? '0 : to_cnt_q + TW'(1);
        if (state_q != S_IDLE && !fall && to_cnt_q == TO_MAX) begin
            state_d  = S_IDLE;
            ferr_set = 1'b1;
            to_cnt_d = '0;
        end
`endif
    end

    // A flag raised in the same cycle as a status-read clear wins over the clear.
    always_comb begin
        ovr_d    = (ovr_q & ~status_rd) | ovr_set;
        ferr_d   = (ferr_q & ~status_rd) | ferr_set;
        perr_d   = (perr_q & ~status_rd) | perr_set;
        kb_int_d = ~empty | ovr_q | ferr_q | perr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_cnt_q <= '0;
            clk_filt_q <= 1'b1;
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_q      <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            kb_int_q   <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            clk_s1_q   <= in_clk;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= in_data;
            dat_s2_q   <= dat_s1_q;
            filt_cnt_q <= filt_cnt_d;
            clk_filt_q <= clk_filt_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_q      <= par_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            kb_int_q   <= kb_int_d;
`ifdef PS2_RX_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    always_comb begin
        status           = '0;
        status[ST_OVR]   = ovr_q;
        status[ST_FERR]  = ferr_q;
        status[ST_PERR]  = perr_q;
        status[ST_FULL]  = full;
        status[ST_CLK]   = clk_filt_q;
        status[ST_LPAR]  = par_q;
        status[ST_RSVD]  = 1'b0;
        status[ST_AVAIL] = ~empty;
        if (addr == REG_STATUS) begin
            data_out = status;
        end else begin
            data_out = empty ? 8'h00 : head;
        end
    end

    assign kb_int = kb_int_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: a PS/2 line driver plus a queue-based model of the receive port.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

    localparam int DEPTH   = 8;
    localparam int FILTER  = 4;
    localparam int TIMEOUT = 16384;

    logic       clk = 1'b0;
    logic       reset;
    logic       addr;
    logic       rd;
    logic [7:0] data_out;
    logic       kb_int;
    logic       in_clk;
    logic       in_data;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    logic [7:0] m_q[$];
    logic       m_ovr, m_ferr, m_perr, m_par;

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FILTER)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .rd       (rd),
        .data_out (data_out),
        .kb_int   (kb_int),
        .in_clk   (in_clk),
        .in_data  (in_data)
    );

    always #5 clk = ~clk;

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic logic [7:0] model_status();
        return {m_ovr, m_ferr, m_perr, (m_q.size() == DEPTH), 1'b1, m_par, 1'b0, (m_q.size() != 0)};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        m_perr = 1'b0;
        m_par  = 1'b0;
    endtask

    // Frame outcome from the receiver's rules: stop error, then parity error, then overrun, else store.
    task automatic model_frame(input logic [7:0] b, input logic par, input logic stp);
        int ones;
        ones = $countones(b) + int'(par);
        m_par = par;
        if (!stp)                   m_ferr = 1'b1;
        else if (ones % 2 == 0)     m_perr = 1'b1;
        else if (m_q.size() == DEPTH) m_ovr = 1'b1;
        else                        m_q.push_back(b);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        in_data = b;
        repeat (4) @(negedge clk);
        in_clk = 1'b0;
        repeat (8) @(negedge clk);
        in_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stp);
        in_data = 1'b1;
        repeat (6) @(negedge clk);
        model_frame(b, par, stp);
    endtask

    task automatic bus_read(input logic a, input string tag);
        logic [7:0] exp;
        @(negedge clk);
        addr = a;
        rd   = 1'b1;
        #1;
        if (a) exp = model_status();
        else   exp = (m_q.size() != 0) ? m_q[0] : 8'h00;
        check(tag, data_out, exp);
        @(negedge clk);
        rd   = 1'b0;
        addr = 1'b0;
        if (a) begin
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
            m_perr = 1'b0;
        end else if (m_q.size() != 0) begin
            void'(m_q.pop_front());
        end
    endtask

    task automatic check_kb(input string tag);
        logic exp;
        repeat (2) @(negedge clk);
        exp = (m_q.size() != 0) | m_ovr | m_ferr | m_perr;
        check(tag, {7'b0, kb_int}, {7'b0, exp});
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0] b;
        int kind;
        int nrd;

        reset   = 1'b1;
        addr    = 1'b0;
        rd      = 1'b0;
        in_clk  = 1'b1;
        in_data = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        $display("[TB] reset state");
        bus_read(1'b1, "reset_status");
        bus_read(1'b0, "reset_data");
        check_kb("reset_kb");

        $display("[TB] single good byte");
        send_frame(8'h1C, odd_par(8'h1C), 1'b1);
        check_kb("kb_after_1c");
        bus_read(1'b1, "status_1c");
        bus_read(1'b0, "data_1c");
        bus_read(1'b1, "status_after_1c");
        check_kb("kb_drained");

        $display("[TB] parity error");
        send_frame(8'hF0, 1'b0, 1'b1);
        check_kb("kb_perr");
        bus_read(1'b1, "status_perr");
        bus_read(1'b1, "status_perr_cleared");
        check_kb("kb_perr_cleared");

        $display("[TB] overrun");
        for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1);
        bus_read(1'b1, "status_ovr");
        for (int i = 0; i < DEPTH; i++) bus_read(1'b0, "data_ovr_drain");
        bus_read(1'b0, "data_ovr_empty");
        bus_read(1'b1, "status_ovr_after");
        check_kb("kb_ovr_done");

        $display("[TB] glitch rejection");
        @(negedge clk);
        in_clk = 1'b0;
        repeat (FILTER - 1) @(negedge clk);
        in_clk = 1'b1;
        repeat (10) @(negedge clk);
        bus_read(1'b1, "status_glitch");
        send_frame(8'h3C, odd_par(8'h3C), 1'b1);
        bus_read(1'b0, "data_after_glitch");

        $display("[TB] stop error");
        send_frame(8'h55, odd_par(8'h55), 1'b0);
        bus_read(1'b1, "status_ferr");
        check_kb("kb_ferr_cleared");

        $display("[TB] reset mid-frame");
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        pulse_reset();
        bus_read(1'b1, "status_midreset");
        send_frame(8'h5A, odd_par(8'h5A), 1'b1);
        bus_read(1'b1, "status_5a");
        bus_read(1'b0, "data_5a");

`ifdef PS2_RX_TIMEOUT_EN
        $display("[TB] timeout");
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        repeat (TIMEOUT + 40) @(negedge clk);
        m_ferr = 1'b1;
        bus_read(1'b1, "status_timeout");
        send_frame(8'h29, odd_par(8'h29), 1'b1);
        bus_read(1'b0, "data_29");
`endif

        $display("[TB] randomized frames");
        for (int n = 0; n < 25; n++) begin
            b    = 8'($urandom);
            kind = $urandom_range(0, 9);
            if (kind == 0)      send_frame(b, ~odd_par(b), 1'b1);
            else if (kind == 1) send_frame(b, odd_par(b), 1'b0);
            else                send_frame(b, odd_par(b), 1'b1);
            nrd = $urandom_range(0, 2);
            for (int r = 0; r < nrd; r++) bus_read(1'b0, "rand_data");
            if ($urandom_range(0, 3) == 0) bus_read(1'b1, "rand_status");
            check_kb("rand_kb");
        end
        bus_read(1'b1, "final_status");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
